// File: rtl/register_column_pkg.sv
// Shared types and helpers for the multi-port register column: sweep state
// encoding, strobe-width helper and the byte-merge used by writes and bypass.
package register_column_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } sweep_state_e;

  // Merge operands are carried at a fixed maximum width; callers cast in and out.
  localparam int unsigned MAX_DATA_W = 256;
  localparam int unsigned MAX_STRB_W = MAX_DATA_W / 8;

  typedef logic [MAX_DATA_W-1:0] word_t;
  typedef logic [MAX_STRB_W-1:0] strb_t;

  function automatic int unsigned strb_width(input int unsigned data_w);
    return data_w / 8;
  endfunction

  function automatic word_t merge_bytes(input word_t old_w, input word_t new_w,
                                        input strb_t strb);
    word_t res;
    res = old_w;
    for (int b = 0; b < int'(MAX_STRB_W); b++) begin
      if (strb[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/register_column_rd_port.sv
// One registered read port: write-first bypass merge, zero data while the
// column is being cleared or when the address lies beyond the array.
module register_column_rd_port
  import register_column_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 10
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic                rd_en_i,
  input  logic [ADDR_W-1:0]   rd_addr_i,
  input  logic [DATA_W-1:0]   mem_word_i,
  input  logic                wr_fire_i,
  input  logic [ADDR_W-1:0]   wr_addr_i,
  input  logic [DATA_W-1:0]   wr_data_i,
  input  logic [DATA_W/8-1:0] wr_strb_i,
  input  logic                clearing_i,
  output logic                rd_valid_o,
  output logic [DATA_W-1:0]   rd_data_o
);

  logic              w_in_range;
  logic              w_hit;
  logic [DATA_W-1:0] w_merged;
  logic [DATA_W-1:0] w_next;
  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  assign w_in_range = 32'(rd_addr_i) < DEPTH;
  assign w_hit      = wr_fire_i && (wr_addr_i == rd_addr_i);
  assign w_merged   = DATA_W'(merge_bytes(word_t'(mem_word_i), word_t'(wr_data_i),
                                          strb_t'(wr_strb_i)));
  assign w_next     = (clearing_i || !w_in_range) ? '0 :
                      (w_hit ? w_merged : mem_word_i);

  // Data only moves on a request so an idle port keeps its last word.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= rd_en_i;
      if (rd_en_i) r_data <= w_next;
    end
  end

  assign rd_valid_o = r_valid;
  assign rd_data_o  = r_data;

endmodule

// File: rtl/register_column_mp.sv
// Multi-port register column: one byte-strobed write port, NUM_RD registered
// read ports, and a counter sweep that zeroes the array after reset or clr_i.
module register_column_mp
  import register_column_pkg::*;
#(
  parameter  int unsigned DATA_W = 8,
  parameter  int unsigned DEPTH  = 1024,
  parameter  int unsigned NUM_RD = 2,
  localparam int unsigned ADDR_W = $clog2(DEPTH),
  localparam int unsigned STRB_W = strb_width(DATA_W)
) (
  input  logic                     clk_i,
  input  logic                     arst_i,
  input  logic                     wr_en_i,
  input  logic [ADDR_W-1:0]        wr_addr_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic [STRB_W-1:0]        wr_strb_i,
  output logic                     wr_ready_o,
  output logic                     wr_err_o,
  input  logic [NUM_RD-1:0]        rd_en_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [NUM_RD-1:0]        rd_valid_o,
  input  logic                     clr_i,
  output logic                     busy_o,
  output sweep_state_e             dbg_state_o
);

  sweep_state_e      r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_err;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_wr_fire;
  logic              w_wr_in_range;
  logic [DATA_W-1:0] w_wr_old;
  logic [DATA_W-1:0] w_wr_merged;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_data;

  assign wr_ready_o  = (r_state == ST_IDLE);
  assign busy_o      = (r_state == ST_CLEAR);
  assign wr_err_o    = r_err;
  assign dbg_state_o = r_state;

  // Handshake: a write is taken on a rising edge where wr_en_i & wr_ready_o; otherwise it is dropped.
  assign w_wr_fire     = wr_en_i && wr_ready_o;
  assign w_wr_in_range = 32'(wr_addr_i) < DEPTH;
  assign w_wr_old      = w_wr_in_range ? r_mem[wr_addr_i] : '0;
  assign w_wr_merged   = DATA_W'(merge_bytes(word_t'(w_wr_old), word_t'(wr_data_i),
                                             strb_t'(wr_strb_i)));

  always_comb begin
    w_mem_we   = 1'b0;
    w_mem_addr = wr_addr_i;
    w_mem_data = w_wr_merged;
    if (r_state == ST_CLEAR) begin
      w_mem_we   = 1'b1;
      w_mem_addr = r_cnt;
      w_mem_data = '0;
    end else if (w_wr_fire && w_wr_in_range) begin
      w_mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_data;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_wr_fire && !w_wr_in_range;
      case (r_state)
        ST_CLEAR: begin
          if (r_cnt == ADDR_W'(DEPTH - 1)) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + ADDR_W'(1);
          end
        end
        ST_IDLE: begin
          if (clr_i) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
          end
        end
        default: r_state <= ST_CLEAR;
      endcase
    end
  end

  for (genvar k = 0; k < int'(NUM_RD); k++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_word;

    assign w_addr = rd_addr_i[k*ADDR_W +: ADDR_W];
    assign w_word = (32'(w_addr) < DEPTH) ? r_mem[w_addr] : '0;

    register_column_rd_port #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH),
      .ADDR_W(ADDR_W)
    ) u_rd (
      .clk_i     (clk_i),
      .arst_i    (arst_i),
      .rd_en_i   (rd_en_i[k]),
      .rd_addr_i (w_addr),
      .mem_word_i(w_word),
      .wr_fire_i (w_wr_fire),
      .wr_addr_i (wr_addr_i),
      .wr_data_i (wr_data_i),
      .wr_strb_i (wr_strb_i),
      .clearing_i(busy_o),
      .rd_valid_o(rd_valid_o[k]),
      .rd_data_o (rd_data_o[k*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_register_column_mp.sv
// Bench for register_column_mp: a 1024-deep and a 1000-deep instance share
// stimulus and are checked every cycle against an array-based reference model.
module tb_register_column_mp;
  import register_column_pkg::*;

  localparam int DW = 8;
  localparam int AW = 10;
  localparam int NR = 2;

  logic          clk = 1'b0;
  logic          arst = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [0:0]    wr_strb = '0;
  logic [NR-1:0] rd_en = '0;
  logic [NR*AW-1:0] rd_addr = '0;
  logic          clr = 1'b0;

  logic             busy_w  [2];
  logic             ready_w [2];
  logic             err_w   [2];
  logic [NR-1:0]    valid_w [2];
  logic [NR*DW-1:0] data_w  [2];
  sweep_state_e     state_w [2];

  // Reference model state, one slot per instance
  logic [DW-1:0] m_mem [2][1024];
  bit            m_clr [2];
  int            m_rem [2];
  bit            m_err [2];
  logic [NR-1:0] m_valid [2];
  logic [DW-1:0] m_data [2][NR];

  logic [DW-1:0] exp_q[$];
  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  register_column_mp #(.DATA_W(8), .DEPTH(1024), .NUM_RD(2)) u_a (
    .clk_i(clk), .arst_i(arst), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .wr_strb_i(wr_strb), .wr_ready_o(ready_w[0]),
    .wr_err_o(err_w[0]), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .rd_data_o(data_w[0]), .rd_valid_o(valid_w[0]), .clr_i(clr),
    .busy_o(busy_w[0]), .dbg_state_o(state_w[0])
  );

  register_column_mp #(.DATA_W(8), .DEPTH(1000), .NUM_RD(2)) u_b (
    .clk_i(clk), .arst_i(arst), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .wr_strb_i(wr_strb), .wr_ready_o(ready_w[1]),
    .wr_err_o(err_w[1]), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .rd_data_o(data_w[1]), .rd_valid_o(valid_w[1]), .clr_i(clr),
    .busy_o(busy_w[1]), .dbg_state_o(state_w[1])
  );

  function automatic int depth_of(input int i);
    return (i == 0) ? 1024 : 1000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset(input int i);
    m_clr[i] = 1'b1;
    m_rem[i] = depth_of(i);
    m_err[i] = 1'b0;
    m_valid[i] = '0;
    for (int k = 0; k < NR; k++) m_data[i][k] = '0;
    for (int a = 0; a < 1024; a++) m_mem[i][a] = '0;
  endtask

  task automatic model_step(input int i);
    int d;
    bit acc;
    int a;
    logic [DW-1:0] w;
    d = depth_of(i);
    acc = wr_en && !m_clr[i];
    for (int k = 0; k < NR; k++) begin
      m_valid[i][k] = rd_en[k];
      if (rd_en[k]) begin
        a = int'(rd_addr[k*AW +: AW]);
        if (m_clr[i] || a >= d) w = '0;
        else begin
          w = m_mem[i][a];
          if (acc && int'(wr_addr) == a && wr_strb[0]) w = wr_data;
        end
        m_data[i][k] = w;
      end
    end
    m_err[i] = acc && int'(wr_addr) >= d;
    if (acc && int'(wr_addr) < d && wr_strb[0]) m_mem[i][wr_addr] = wr_data;
    if (m_clr[i]) begin
      m_rem[i]--;
      if (m_rem[i] == 0) m_clr[i] = 1'b0;
    end else if (clr) begin
      // Everything the sweep will touch ends as zero, and nothing can be written meanwhile
      m_clr[i] = 1'b1;
      m_rem[i] = d;
      for (int x = 0; x < 1024; x++) m_mem[i][x] = '0;
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < NR; k++) exp_q.push_back(m_data[i][k]);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("u%0d.busy", i), 32'(busy_w[i]), 32'(m_clr[i]));
      check($sformatf("u%0d.ready", i), 32'(ready_w[i]), 32'(!m_clr[i]));
      check($sformatf("u%0d.err", i), 32'(err_w[i]), 32'(m_err[i]));
      check($sformatf("u%0d.state_idle", i), 32'(state_w[i] == ST_IDLE), 32'(!m_clr[i]));
      for (int k = 0; k < NR; k++) begin
        check($sformatf("u%0d.valid%0d", i, k), 32'(valid_w[i][k]), 32'(m_valid[i][k]));
        check($sformatf("u%0d.data%0d", i, k), 32'(data_w[i][k*DW +: DW]), 32'(exp_q.pop_front()));
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_step(i);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    arst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) model_reset(i);
    check_outputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    arst = 1'b0;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0;
    rd_en = '0;
    clr   = 1'b0;
  endtask

  task automatic drive_write(input int a, input int d, input bit s);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = DW'(d);
    wr_strb = s;
  endtask

  task automatic drive_read(input int k, input int a);
    rd_en[k] = 1'b1;
    rd_addr[k*AW +: AW] = AW'(a);
  endtask

  function automatic int rnd_addr();
    int sel;
    sel = int'($urandom_range(0, 9));
    if (sel < 7) return int'($urandom_range(0, 15));
    if (sel == 7) return int'($urandom_range(990, 1023));
    return int'($urandom_range(0, 1023));
  endfunction

  initial begin
    #2;
    do_reset();

    // Sweep after reset, then read the top entry
    repeat (1030) step();
    drive_read(0, 1023);
    step();
    idle_inputs();

    // Plain write then read on port 0 only
    drive_write(10, 'hA5, 1'b1);
    step();
    idle_inputs();
    drive_read(0, 10);
    step();
    idle_inputs();

    // Same-cycle write and reads: bypass, then a zero-strobe write
    drive_write(20, 'h3C, 1'b1);
    drive_read(0, 20);
    drive_read(1, 20);
    step();
    drive_write(20, 'h77, 1'b0);
    step();
    idle_inputs();
    step();

    // Address beyond the smaller array
    drive_write(1010, 'h5A, 1'b1);
    step();
    idle_inputs();
    step();
    drive_read(0, 1010);
    drive_read(1, 1010);
    step();
    idle_inputs();

    // Clear request with a read of freshly written data during the sweep
    drive_write(5, 'hFF, 1'b1);
    step();
    wr_en = 1'b0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    drive_read(0, 5);
    repeat (5) step();
    idle_inputs();
    repeat (300) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (750) step();
    drive_read(1, 5);
    step();
    idle_inputs();

    // Reset in the middle of a sweep
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (500) step();
    do_reset();
    repeat (1030) step();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      wr_en   = ($urandom_range(0, 1) == 1);
      wr_addr = AW'(rnd_addr());
      wr_data = DW'($urandom);
      wr_strb = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < NR; k++) begin
        rd_en[k] = ($urandom_range(0, 2) != 0);
        rd_addr[k*AW +: AW] = ($urandom_range(0, 3) == 0) ? wr_addr : AW'(rnd_addr());
      end
      clr = ($urandom_range(0, 499) == 0);
      step();
    end
    idle_inputs();
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/register_column_mp.md
Name: register_column_mp

Overview:
- Parametrised successor to the single-port register column.
- Storage array of DEPTH words, each DATA_W bits wide.
- One write port with byte strobes; NUM_RD independent registered read ports with write-first bypass.
- Counter-driven clear sequencer zeroes the array after reset or on request; sits in datapath/scratch storage wherever a column was used.

Parameters:
DATA_W, 8, word width in bits; multiple of 8
DEPTH, 1024, number of words; any value ≥2, need not be power of two
NUM_RD, 2, number of read ports, ≥1
ADDR_W, $clog2(DEPTH), address width (derived, not overridden)

Ports:
clk_i  in  1  clock, all logic on rising edge
arst_i  in  1  reset, asynchronous, active-high
wr_en_i  in  1  write request
wr_addr_i  in  ADDR_W  write address
wr_data_i  in  DATA_W  write data
wr_strb_i  in  DATA_W/8  byte enables for write
wr_ready_o  out  1  write accepted when wr_en_i & wr_ready_o
wr_err_o  out  1  one-cycle pulse: accepted write had wr_addr_i ≥ DEPTH
rd_en_i  in  NUM_RD  per-port read request
rd_addr_i  in  NUM_RD*ADDR_W  per-port read address, port k at [k*ADDR_W +: ADDR_W]
rd_data_o  out  NUM_RD*DATA_W  per-port read data, same packing
rd_valid_o  out  NUM_RD  per-port data valid, one cycle after request
clr_i  in  1  request full array clear
busy_o  out  1  clear sweep in progress

Behaviour:
- Reset values:
  - Async assert: FSM->CLEAR, sweep counter=0, busy_o=1, wr_ready_o=0, wr_err_o=0, rd_valid_o=0, rd_data_o=0.
  - Array is not reset directly; it is zeroed by the sweep.
- FSM states: CLEAR, IDLE.
  - CLEAR: write index = counter with all-ones strobe, data 0; counter increments each cycle. At counter==DEPTH-1, write that entry and go to IDLE next cycle.
  - Sweep lasts exactly DEPTH cycles after reset deassertion.
  - IDLE: clr_i=1 -> CLEAR, counter=0. busy_o rises the cycle after clr_i is sampled.
  - clr_i while in CLEAR: ignored; no restart.
  - Reset mid-sweep: restart from 0.
- wr_ready_o = (state==IDLE).
  - A write presented while not ready is dropped, not queued.
  - Accepted write updates only bytes with wr_strb_i set.
  - Accepted write with wr_strb_i=0: no change, no error.
- Out-of-range write (addr ≥ DEPTH, accepted): array unchanged; wr_err_o=1 for the following cycle only.
- Read, port k:
  - rd_en_i[k] sampled at edge N -> rd_valid_o[k]=1 and rd_data_o[k] valid during cycle N+1.
  - rd_valid_o[k]=0 when not requested; rd_data_o[k] holds its last value.
  - Latency fixed at 1 in all states.
- Bypass (write-first): if an accepted write targets the same address as a read in the same cycle, read data = old word merged with strobed new bytes.
- Ports are independent; any number may read the same address in the same cycle.
- Read during CLEAR: valid asserted, data forced to 0 regardless of sweep progress.
- Read with addr ≥ DEPTH: valid asserted, data 0.
- Simultaneous clr_i and accepted write in IDLE: write performed that cycle; sweep starts next cycle and overwrites it.

Decomposition:
- Package register_column_pkg:
  - sweep state enum (CLEAR, IDLE)
  - byte-merge function (old, new, strb)
  - localparam helpers for strobe width
- Sub-module register_column_rd_port: one registered read port with bypass merge and out-of-range/clear zeroing. Instantiated NUM_RD times via generate.
- Top holds array, FSM, counter, write logic.

Test Plan:
1. Reset pulse, then idle -> busy_o=1 and wr_ready_o=0 for exactly 1024 cycles after arst_i falls; then busy_o=0, wr_ready_o=1. Read of addr 1023 returns 0x00 with rd_valid_o=1.
2. Write 0xA5 to addr 10 with strb=1; next cycle read port 0 at addr 10 -> 0xA5 one cycle later, rd_valid_o[0]=1. Port 1 not enabled -> rd_valid_o[1]=0.
3. Write 0x3C to addr 20 while both ports read addr 20 in the same cycle -> both return 0x3C next cycle (bypass). Repeat with strb=0 -> both return old value.
4. Parameter DEPTH=1000: write to addr 1010 -> wr_err_o pulses one cycle, no entry changed. Read addr 1010 -> 0x00, valid=1.
5. Write 0xFF to addr 5, assert clr_i, then read addr 5 during sweep -> 0x00. After busy_o falls, addr 5 reads 0x00. clr_i pulsed mid-sweep does not extend the 1024-cycle duration.
6. Assert arst_i at sweep count 500 -> outputs return to reset values immediately. After release, the sweep takes the full 1024 cycles again.
